// File: rtl/rf_bank_arbiter.sv
// rtl/rf_bank_arbiter.sv - register-file bank arbiter for four operand collectors
// Eight request slots (two per OC) compete round-robin per bank; CDB writes take priority.
module rf_bank_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        Alloc_Valid,
  input  logic [1:0]  Alloc_OCID,
  input  logic        Src1_Valid,
  input  logic        Src2_Valid,
  input  logic [1:0]  Src1_Bank,
  input  logic [1:0]  Src2_Bank,
  input  logic [2:0]  Src1_Row,
  input  logic [2:0]  Src2_Row,
  input  logic        Src_Same,
  input  logic        WriteEn_CDB,
  input  logic [1:0]  WriteBank_CDB,
  output logic        Alloc_Stall,
  output logic [3:0]  RF_RdEn,
  output logic [11:0] RF_RdRow,
  output logic [11:0] RF_RdSlot,
  output logic [7:0]  Rd_Done,
  output logic [7:0]  Pending
);

  logic [7:0] pend_q;
  logic [1:0] slot_bank [8];
  logic [2:0] slot_row  [8];
  logic [3:0] same_q;
  logic [2:0] ptr       [4];
  logic [7:0] done_q;

  logic [3:0] gnt_vld;
  logic [2:0] gnt_slot  [4];
  logic [7:0] pend_clr;
  logic [7:0] pend_set;
  logic [7:0] done_next;
  logic [3:0] same_clr;
  logic [2:0] s1_slot;
  logic [2:0] s2_slot;
  logic       accept;

  assign s1_slot     = {Alloc_OCID, 1'b0};
  assign s2_slot     = {Alloc_OCID, 1'b1};
  assign Alloc_Stall = Alloc_Valid & (pend_q[s1_slot] | pend_q[s2_slot]);
  assign accept      = Alloc_Valid & ~Alloc_Stall;

  // Grants look only at registered state, so a same-cycle allocation is never granted.
  always_comb begin
    logic [2:0] idx;
    idx     = '0;
    gnt_vld = '0;
    for (int b = 0; b < 4; b++) begin
      gnt_slot[b] = '0;
      for (int i = 0; i < 8; i++) begin
        idx = ptr[b] + 3'(i);
        if (!gnt_vld[b] && pend_q[idx] && slot_bank[idx] == 2'(b) &&
            !(WriteEn_CDB && WriteBank_CDB == 2'(b))) begin
          gnt_vld[b]  = 1'b1;
          gnt_slot[b] = idx;
        end
      end
    end
  end

  always_comb begin
    RF_RdRow  = '0;
    RF_RdSlot = '0;
    pend_clr  = '0;
    done_next = '0;
    same_clr  = '0;
    for (int b = 0; b < 4; b++) begin
      if (gnt_vld[b]) begin
        RF_RdRow[3*b +: 3]  = slot_row[gnt_slot[b]];
        RF_RdSlot[3*b +: 3] = gnt_slot[b];
        pend_clr[gnt_slot[b]]  = 1'b1;
        done_next[gnt_slot[b]] = 1'b1;
        // A shared-register read also completes the OC's Src2 operand.
        if (!gnt_slot[b][0] && same_q[gnt_slot[b][2:1]]) begin
          done_next[{gnt_slot[b][2:1], 1'b1}] = 1'b1;
          same_clr[gnt_slot[b][2:1]]          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_set = '0;
    if (accept && Src1_Valid)               pend_set[s1_slot] = 1'b1;
    if (accept && Src2_Valid && !Src_Same)  pend_set[s2_slot] = 1'b1;
  end

  assign RF_RdEn = gnt_vld;
  assign Rd_Done = done_q;
  assign Pending = pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      same_q <= '0;
      done_q <= '0;
      for (int s = 0; s < 8; s++) begin
        slot_bank[s] <= '0;
        slot_row[s]  <= '0;
      end
      for (int b = 0; b < 4; b++) ptr[b] <= '0;
    end else begin
      done_q <= done_next;
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      for (int b = 0; b < 4; b++) begin
        if (gnt_vld[b]) ptr[b] <= gnt_slot[b] + 3'd1;
      end
      same_q <= same_q & ~same_clr;
      if (accept && (Src1_Valid || Src2_Valid)) same_q[Alloc_OCID] <= Src_Same & Src1_Valid;
      if (accept && Src1_Valid) begin
        slot_bank[s1_slot] <= Src1_Bank;
        slot_row[s1_slot]  <= Src1_Row;
      end
      if (accept && Src2_Valid && !Src_Same) begin
        slot_bank[s2_slot] <= Src2_Bank;
        slot_row[s2_slot]  <= Src2_Row;
      end
    end
  end

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// tb/tb_rf_bank_arbiter.sv - scoreboard bench for rf_bank_arbiter
// Stimulus queues cycle-stamped grant/Rd_Done expectations; a negedge monitor pops and compares.
module tb_rf_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        Alloc_Valid;
  logic [1:0]  Alloc_OCID;
  logic        Src1_Valid, Src2_Valid;
  logic [1:0]  Src1_Bank, Src2_Bank;
  logic [2:0]  Src1_Row, Src2_Row;
  logic        Src_Same;
  logic        WriteEn_CDB;
  logic [1:0]  WriteBank_CDB;
  logic        Alloc_Stall;
  logic [3:0]  RF_RdEn;
  logic [11:0] RF_RdRow;
  logic [11:0] RF_RdSlot;
  logic [7:0]  Rd_Done;
  logic [7:0]  Pending;

  rf_bank_arbiter dut (
    .clk(clk), .rst(rst), .Alloc_Valid(Alloc_Valid), .Alloc_OCID(Alloc_OCID),
    .Src1_Valid(Src1_Valid), .Src2_Valid(Src2_Valid),
    .Src1_Bank(Src1_Bank), .Src2_Bank(Src2_Bank),
    .Src1_Row(Src1_Row), .Src2_Row(Src2_Row), .Src_Same(Src_Same),
    .WriteEn_CDB(WriteEn_CDB), .WriteBank_CDB(WriteBank_CDB),
    .Alloc_Stall(Alloc_Stall), .RF_RdEn(RF_RdEn), .RF_RdRow(RF_RdRow),
    .RF_RdSlot(RF_RdSlot), .Rd_Done(Rd_Done), .Pending(Pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] en; logic [11:0] row; logic [11:0] slot; } gnt_t;
  typedef struct { int cyc; logic [7:0] mask; } done_t;
  gnt_t  gnt_q  [$];
  done_t done_q [$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_gnt(input int c, input logic [3:0] en, input logic [11:0] row, input logic [11:0] slot);
    gnt_t g;
    g.cyc = c; g.en = en; g.row = row; g.slot = slot;
    gnt_q.push_back(g);
  endtask

  task automatic push_done(input int c, input logic [7:0] mask);
    done_t d;
    d.cyc = c; d.mask = mask;
    done_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Alloc_Valid = 0; Alloc_OCID = 0; Src1_Valid = 0; Src2_Valid = 0;
    Src1_Bank = 0; Src2_Bank = 0; Src1_Row = 0; Src2_Row = 0; Src_Same = 0;
    WriteEn_CDB = 0; WriteBank_CDB = 0;
  endtask

  task automatic alloc(input logic [1:0] oc, input logic v1, input logic [1:0] b1, input logic [2:0] r1,
                       input logic v2, input logic [1:0] b2, input logic [2:0] r2, input logic same);
    Alloc_Valid = 1; Alloc_OCID = oc;
    Src1_Valid = v1; Src1_Bank = b1; Src1_Row = r1;
    Src2_Valid = v2; Src2_Bank = b2; Src2_Row = r2; Src_Same = same;
  endtask

  task automatic cdb(input logic [1:0] bank);
    WriteEn_CDB = 1; WriteBank_CDB = bank;
  endtask

  // Monitor: outputs are compared only against queued expectations for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
          gnt_t g;
          g = gnt_q.pop_front();
          check("grant_en",   32'(RF_RdEn),   32'(g.en));
          check("grant_row",  32'(RF_RdRow),  32'(g.row));
          check("grant_slot", 32'(RF_RdSlot), 32'(g.slot));
        end else if (RF_RdEn != 0) begin
          check("unexpected_grant", 32'(RF_RdEn), 32'd0);
        end
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          done_t d;
          d = done_q.pop_front();
          check("rd_done", 32'(Rd_Done), 32'(d.mask));
        end else if (Rd_Done != 0) begin
          check("unexpected_rd_done", 32'(Rd_Done), 32'd0);
        end
      end
    end
  end

  initial begin
    int t;
    idle();
    rst = 1;
    alloc(2'd0, 1, 2'd0, 3'd1, 1, 2'd1, 3'd2, 0);
    step(); step();
    rst = 0; idle();
    check("reset_pending", 32'(Pending), 32'd0);
    check("reset_rden",    32'(RF_RdEn), 32'd0);
    check("reset_rddone",  32'(Rd_Done), 32'd0);
    step();

    // Parallel grants on banks 2 and 3
    t = cyc;
    alloc(2'd1, 1, 2'd2, 3'd5, 1, 2'd3, 3'd1, 0);
    push_gnt(t + 1, 4'b1100, 12'h340, 12'h680);
    push_done(t + 2, 8'h0C);
    step(); idle();
    check("parallel_pending", 32'(Pending), 32'h0C);
    step(); step();
    check("parallel_cleared", 32'(Pending), 32'd0);

    // Same-bank conflict with a CDB write blocking bank 1 for one cycle
    t = cyc;
    alloc(2'd0, 1, 2'd1, 3'd2, 1, 2'd1, 3'd6, 0);
    push_gnt(t + 2, 4'b0010, 12'h010, 12'h000);
    push_gnt(t + 3, 4'b0010, 12'h030, 12'h008);
    push_done(t + 3, 8'h01);
    push_done(t + 4, 8'h02);
    step(); idle(); cdb(2'd1);
    step(); idle();
    step(); step(); step();

    // Shared operand: one read completes both slots of OC2
    t = cyc;
    alloc(2'd2, 1, 2'd0, 3'd3, 1, 2'd0, 3'd3, 1);
    push_gnt(t + 1, 4'b0001, 12'h003, 12'h004);
    push_done(t + 2, 8'h30);
    step(); idle();
    check("same_pending", 32'(Pending), 32'h10);
    step(); step();

    // Round-robin on bank 0 from a fresh pointer
    rst = 1; step(); rst = 0;
    alloc(2'd0, 1, 2'd0, 3'd1, 0, 2'd0, 3'd0, 0); cdb(2'd0);
    step(); alloc(2'd1, 1, 2'd0, 3'd2, 0, 2'd0, 3'd0, 0); cdb(2'd0);
    step(); alloc(2'd2, 1, 2'd0, 3'd4, 0, 2'd0, 3'd0, 0); cdb(2'd0);
    step(); idle();
    t = cyc;
    alloc(2'd0, 1, 2'd0, 3'd5, 0, 2'd0, 3'd0, 0);
    #1;
    check("rr_pending", 32'(Pending), 32'h15);
    check("rr_stall_in_grant_cycle", 32'(Alloc_Stall), 32'd1);
    push_gnt(t,     4'b0001, 12'h001, 12'h000);
    push_gnt(t + 1, 4'b0001, 12'h002, 12'h002);
    push_gnt(t + 2, 4'b0001, 12'h004, 12'h004);
    push_gnt(t + 3, 4'b0001, 12'h007, 12'h000);
    push_done(t + 1, 8'h01);
    push_done(t + 2, 8'h04);
    push_done(t + 3, 8'h10);
    push_done(t + 4, 8'h01);
    step();
    alloc(2'd0, 1, 2'd0, 3'd7, 0, 2'd0, 3'd0, 0);
    #1;
    check("rr_realloc_stall", 32'(Alloc_Stall), 32'd0);
    step(); idle();
    step(); step(); step();

    // Stall while slot 2 is held pending by CDB writes to bank 1
    alloc(2'd1, 1, 2'd1, 3'd3, 0, 2'd0, 3'd0, 0); cdb(2'd1);
    step();
    alloc(2'd1, 1, 2'd2, 3'd6, 0, 2'd0, 3'd0, 0); cdb(2'd1);
    #1;
    check("stall_asserted", 32'(Alloc_Stall), 32'd1);
    step(); idle();
    t = cyc;
    check("stall_pending_kept", 32'(Pending), 32'h04);
    push_gnt(t, 4'b0010, 12'h018, 12'h010);
    push_done(t + 1, 8'h04);
    step();
    alloc(2'd1, 1, 2'd2, 3'd6, 0, 2'd0, 3'd0, 0);
    #1;
    check("stall_retry", 32'(Alloc_Stall), 32'd0);
    push_gnt(t + 2, 4'b0100, 12'h180, 12'h080);
    push_done(t + 3, 8'h04);
    step(); idle();
    step(); step();

    // Accept with no valid source changes nothing
    alloc(2'd3, 0, 2'd1, 3'd1, 0, 2'd2, 3'd2, 0);
    #1;
    check("novalid_stall", 32'(Alloc_Stall), 32'd0);
    step(); idle();
    check("novalid_pending", 32'(Pending), 32'd0);
    step(); step();

    // Reset during the grant cycle drops the request
    alloc(2'd3, 1, 2'd3, 3'd2, 0, 2'd0, 3'd0, 0);
    step(); idle(); rst = 1;
    step(); rst = 0;
    check("midrst_pending", 32'(Pending), 32'd0);
    check("midrst_rddone",  32'(Rd_Done), 32'd0);
    step();
    check("midrst_rddone_after", 32'(Rd_Done), 32'd0);
    check("midrst_rden",         32'(RF_RdEn), 32'd0);
    step(); step(); step();

    check("grant_queue_drained", 32'(gnt_q.size()),  32'd0);
    check("done_queue_drained",  32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
